// File: rtl/bit_sequence_generator_if.sv
// Control/status bundle for bit_sequence_generator.
// Carries i_loop only when BIT_SEQ_GEN_LOOP_EN is defined.
interface bit_sequence_generator_if #(
    parameter int unsigned PATTERN_W = 7,
    parameter int unsigned LEN_W     = 4
);
    logic                 i_start;
    logic                 i_stop;
    logic [PATTERN_W-1:0] i_pattern;
    logic [LEN_W-1:0]     i_length;
`ifdef BIT_SEQ_GEN_LOOP_EN
    logic                 i_loop;
`endif
    logic                 o_bit0_pulse;
    logic                 o_bit1_pulse;
    logic                 o_busy;
    logic                 o_done;
    logic [LEN_W-1:0]     o_sent_count;

    modport master (
`ifdef BIT_SEQ_GEN_LOOP_EN
        output i_loop,
`endif
        output i_start, i_stop, i_pattern, i_length,
        input  o_bit0_pulse, o_bit1_pulse, o_busy, o_done, o_sent_count
    );

    modport slave (
`ifdef BIT_SEQ_GEN_LOOP_EN
        input  i_loop,
`endif
        input  i_start, i_stop, i_pattern, i_length,
        output o_bit0_pulse, o_bit1_pulse, o_busy, o_done, o_sent_count
    );
endinterface

// File: rtl/bit_sequence_generator.sv
// Plays the low Lc pattern bits MSB first as one-cycle 0/1 pulses, GAP_CYCLES idle cycles apart.
// Optional continuous playback is enabled by defining BIT_SEQ_GEN_LOOP_EN.
module bit_sequence_generator #(
    parameter int unsigned PATTERN_W  = 7,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input logic                     clk,
    input logic                     reset,
    bit_sequence_generator_if.slave bus
);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StEmit, StGap, StDone} state_e;

    state_e               state_q;
    logic [PATTERN_W-1:0] shift_q;
    logic [LEN_W-1:0]     rem_q;
    logic [LEN_W-1:0]     sent_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 bit0_q, bit1_q, busy_q, done_q;
`ifdef BIT_SEQ_GEN_LOOP_EN
    logic [PATTERN_W-1:0] pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 loop_q;
`endif

    logic [LEN_W-1:0]     lc;
    logic [PATTERN_W-1:0] aligned;

    // Left-align the pattern so the next bit to send is always the MSB.
    always_comb begin
        lc      = (bus.i_length > LEN_W'(PATTERN_W)) ? LEN_W'(PATTERN_W) : bus.i_length;
        aligned = bus.i_pattern << (LEN_W'(PATTERN_W) - lc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            rem_q   <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
            bit0_q  <= 1'b0;
            bit1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BIT_SEQ_GEN_LOOP_EN
            pat_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
`endif
        end else begin
            bit0_q <= 1'b0;
            bit1_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.i_stop) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle, StDone: begin
                        if (bus.i_start) begin
`ifdef BIT_SEQ_GEN_LOOP_EN
                            pat_q  <= aligned;
                            len_q  <= lc;
                            loop_q <= bus.i_loop;
`endif
                            if (lc != '0) begin
                                state_q <= StEmit;
                                busy_q  <= 1'b1;
                                bit1_q  <= aligned[PATTERN_W-1];
                                bit0_q  <= ~aligned[PATTERN_W-1];
                                shift_q <= aligned << 1;
                                rem_q   <= lc - LEN_W'(1);
                                sent_q  <= LEN_W'(1);
                            end else begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                shift_q <= aligned;
                                rem_q   <= '0;
                                sent_q  <= '0;
                            end
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    StEmit: begin
                        state_q <= StGap;
                        gap_q   <= GAP_W'(GAP_CYCLES - 1);
                    end
                    StGap: begin
                        if (gap_q != '0) begin
                            gap_q <= gap_q - GAP_W'(1);
                        end else if (rem_q != '0) begin
                            state_q <= StEmit;
                            bit1_q  <= shift_q[PATTERN_W-1];
                            bit0_q  <= ~shift_q[PATTERN_W-1];
                            shift_q <= shift_q << 1;
                            rem_q   <= rem_q - LEN_W'(1);
                            sent_q  <= sent_q + LEN_W'(1);
`ifdef BIT_SEQ_GEN_LOOP_EN
                        end else if (loop_q) begin
                            // Wrap straight into bit 0; o_done marks the pass boundary.
                            state_q <= StEmit;
                            bit1_q  <= pat_q[PATTERN_W-1];
                            bit0_q  <= ~pat_q[PATTERN_W-1];
                            shift_q <= pat_q << 1;
                            rem_q   <= len_q - LEN_W'(1);
                            sent_q  <= LEN_W'(1);
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_bit0_pulse = bit0_q;
    assign bus.o_bit1_pulse = bit1_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_sent_count = sent_q;

endmodule

// File: tb/tb_bit_sequence_generator.sv
// Scoreboard bench for bit_sequence_generator: stimulus queues expected pulse/done events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_bit_sequence_generator;
    localparam int G = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cyc;
        int kind;  // 0/1 = bit pulse value, 2 = done
        int sent;
    } ev_t;
    ev_t exp_q[$];

    bit_sequence_generator_if bus ();

    bit_sequence_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void push(int c, int k, int s);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.sent = s;
        exp_q.push_back(e);
    endfunction

    // Monitor: every emitted pulse/done must match the head of the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (reset === 1'b0) begin
            if (bus.o_bit0_pulse === 1'b1 || bus.o_bit1_pulse === 1'b1) begin
                chk("pulse_exclusive", 32'(bus.o_bit0_pulse & bus.o_bit1_pulse), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_pulse at cycle %0d: got bit %0d expected none",
                             cyc, bus.o_bit1_pulse);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_value", 32'(bus.o_bit1_pulse), e.kind);
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_sent", 32'(bus.o_sent_count), e.sent);
                end
            end
            if (bus.o_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_done at cycle %0d: got done expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 2, e.kind);
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_sent", 32'(bus.o_sent_count), e.sent);
                end
            end
        end
    end

    // Start a sequence in the current cycle t; optionally re-assert start or assert stop at t+n.
    task automatic run_seq(input logic [6:0] pat, input int len, input int restart_at,
                           input int stop_at);
        int t, lc, last, npulse;
        @(posedge clk);
        #1;
        t = cyc;
        bus.i_start   = 1'b1;
        bus.i_pattern = pat;
        bus.i_length  = 4'(len);
        lc     = (len > 7) ? 7 : len;
        npulse = 0;
        for (int k = 0; k < lc; k++) begin
            if (stop_at == 0 || k * (G + 1) + 1 <= stop_at) begin
                push(t + 1 + k * (G + 1), int'(pat[lc-1-k]), k + 1);
                npulse++;
            end
        end
        if (stop_at == 0) push(t + lc * (G + 1) + 1, 2, lc);
        last = (stop_at > 0) ? stop_at + 1 : lc * (G + 1) + 1;
        for (int n = 1; n <= last + 2; n++) begin
            @(posedge clk);
            #1;
            bus.i_start   = (n == restart_at);
            bus.i_stop    = (n == stop_at);
            bus.i_pattern = ~pat;
            bus.i_length  = 4'd5;
            @(negedge clk);
            if (n == 1) chk("busy_after_start", 32'(bus.o_busy), (lc > 0) ? 1 : 0);
            if (lc == 0) chk("busy_zero_len", 32'(bus.o_busy), 0);
            if (n == last - 1 && last > 1) chk("busy_before_end", 32'(bus.o_busy), 1);
            if (n == last) chk("busy_at_end", 32'(bus.o_busy), 0);
        end
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        chk("sent_count_final", 32'(bus.o_sent_count), npulse);
    endtask

    initial begin
        reset         = 1'b1;
        bus.i_start   = 1'b1;
        bus.i_stop    = 1'b0;
        bus.i_pattern = 7'b1111111;
        bus.i_length  = 4'd7;
`ifdef BIT_SEQ_GEN_LOOP_EN
        bus.i_loop    = 1'b0;
`endif
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_outputs", {bus.o_bit0_pulse, bus.o_bit1_pulse, bus.o_busy, bus.o_done,
                                  bus.o_sent_count}, 0);
        end
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        chk("after_release", {bus.o_bit0_pulse, bus.o_bit1_pulse, bus.o_busy, bus.o_done,
                              bus.o_sent_count}, 0);

        run_seq(7'b1011001, 7, 0, 0);   // 1,0,1,1,0,0,1
        run_seq(7'b0000110, 3, 0, 0);   // 1,1,0
        run_seq(7'b0000110, 15, 0, 0);  // clamped to 7: 0,0,0,0,1,1,0
        run_seq(7'b1010101, 0, 0, 0);   // done only
        run_seq(7'b0110101, 7, 3, 0);   // restart while busy is ignored
        run_seq(7'b1110000, 7, 0, 8);   // stop after two pulses

        // Start and stop together in IDLE: stop wins, count retained.
        @(posedge clk);
        #1;
        bus.i_start   = 1'b1;
        bus.i_stop    = 1'b1;
        bus.i_pattern = 7'b1111111;
        bus.i_length  = 4'd7;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        @(negedge clk);
        chk("start_stop_busy", 32'(bus.o_busy), 0);
        chk("start_stop_sent", 32'(bus.o_sent_count), 2);
        repeat (3) @(posedge clk);

`ifdef BIT_SEQ_GEN_LOOP_EN
        begin
            int t;
            @(posedge clk);
            #1;
            t = cyc;
            bus.i_loop    = 1'b1;
            bus.i_pattern = 7'b0000010;
            bus.i_length  = 4'd2;
            bus.i_start   = 1'b1;
            push(t + 1, 1, 1);
            push(t + 6, 0, 2);
            push(t + 11, 1, 1);
            push(t + 11, 2, 1);
            push(t + 16, 0, 2);
            push(t + 21, 1, 1);
            push(t + 21, 2, 1);
            for (int n = 1; n <= 24; n++) begin
                @(posedge clk);
                #1;
                bus.i_start = 1'b0;
                bus.i_stop  = (n == 22);
                @(negedge clk);
                if (n == 21) chk("loop_busy", 32'(bus.o_busy), 1);
                if (n == 23) chk("loop_stop_busy", 32'(bus.o_busy), 0);
            end
            bus.i_stop = 1'b0;
            bus.i_loop = 1'b0;
        end
`endif

        repeat (5) @(posedge clk);
        chk("missing_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
